// File: rtl/jtpopeye_scan2x_if.sv
// Video bus around the Popeye line doubler: 15 kHz RGB/blank/sync in, 31 kHz stream out.
// The master drives the source side and consumes the doubled output; the doubler is the slave.
interface jtpopeye_scan2x_if;
  logic       pxl_cen;
  logic       pxl2_cen;
  logic       en;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       HB;
  logic       VB;
  logic       HS;
  logic       VS;
  logic [2:0] red2x;
  logic [2:0] green2x;
  logic [1:0] blue2x;
  logic       HS2x;
  logic       VS2x;
  logic       blank2x;
  logic       cen2x;

  modport master (
    output pxl_cen, pxl2_cen, en, red, green, blue, HB, VB, HS, VS,
    input  red2x, green2x, blue2x, HS2x, VS2x, blank2x, cen2x
  );

  modport slave (
    input  pxl_cen, pxl2_cen, en, red, green, blue, HB, VB, HS, VS,
    output red2x, green2x, blue2x, HS2x, VS2x, blank2x, cen2x
  );
endinterface

// File: rtl/jtpopeye_scan2x.sv
// Line doubler: each input line lands in one bank of a ping-pong buffer while the
// other bank is replayed twice at pxl2_cen. With en=0 it is a pxl_cen-registered passthrough.
module jtpopeye_scan2x #(
  parameter int AW  = 9,
  parameter int HSW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  jtpopeye_scan2x_if.slave vid
);
  localparam logic [AW-1:0] XMAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [AW:0]   HSW_L = (AW+1)'(HSW);

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] x);
    return (x == XMAX) ? x : x + ONE;
  endfunction

  function automatic logic [7:0] blank_rgb(input logic blank, input logic [7:0] rgb);
    return blank ? 8'd0 : rgb;
  endfunction

  logic [8:0]    mem [0:(2**(AW+1))-1];

  logic          hs_l_q, hs_l_d;
  logic          bank_q, bank_d;
  logic          vb_l_q, vb_l_d;
  logic          vs_l_q, vs_l_d;
  logic          wr_ok_q, wr_ok_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_x_q, wr_x_d;
  logic [AW-1:0] rd_x_q, rd_x_d;
  logic [AW-1:0] line_len_q, line_len_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hs2x_q, hs2x_d;
  logic          vs2x_q, vs2x_d;
  logic          blank2x_q, blank2x_d;

  logic          line_start;
  logic          rd_step;
  logic          last_rd;
  logic          we;
  logic [AW:0]   wr_addr;
  logic [8:0]    wr_word;
  logic [8:0]    rd_word;

  always_comb begin
    line_start = vid.pxl_cen & vid.HS & ~hs_l_q;
    // a restart on the same clk as pxl2_cen suppresses the read from the old position
    rd_step    = vid.pxl2_cen & ~done_q & ~line_start;
    last_rd    = (rd_x_q == line_len_q - ONE);
    wr_word    = {vid.HB, vid.red, vid.green, vid.blue};
    we         = vid.pxl_cen & vid.en & (line_start | (wr_x_q != XMAX));
    wr_addr    = line_start ? {~bank_q, {AW{1'b0}}} : {bank_q, wr_x_q};
    rd_word    = mem[{~bank_q, rd_x_q}];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_word;
  end

  always_comb begin
    hs_l_d     = hs_l_q;
    bank_d     = bank_q;
    vb_l_d     = vb_l_q;
    vs_l_d     = vs_l_q;
    wr_ok_d    = wr_ok_q & vid.en;
    pass_d     = pass_q;
    done_d     = done_q;
    wr_x_d     = wr_x_q;
    rd_x_d     = rd_x_q;
    line_len_d = line_len_q;
    if (vid.pxl_cen) begin
      hs_l_d = vid.HS;
      wr_x_d = sat_inc(wr_x_q);
    end
    if (line_start) begin
      // wr_ok marks a bank filled entirely with en=1 since reset; otherwise its replay is black
      line_len_d = wr_x_q;
      bank_d     = ~bank_q;
      wr_x_d     = ONE;
      vb_l_d     = vid.VB;
      vs_l_d     = vid.VS;
      wr_ok_d    = vid.en;
      rd_x_d     = '0;
      pass_d     = 1'b0;
      done_d     = (wr_x_q == '0) | ~wr_ok_q | ~vid.en;
    end else if (rd_step) begin
      if (last_rd) begin
        rd_x_d = '0;
        if (pass_q) done_d = 1'b1;
        else        pass_d = 1'b1;
      end else begin
        rd_x_d = rd_x_q + ONE;
      end
    end
  end

  // output stage: one pxl2 tick behind the read address, or one pxl tick in passthrough
  always_comb begin
    rgb_d     = rgb_q;
    hs2x_d    = hs2x_q;
    vs2x_d    = vs2x_q;
    blank2x_d = blank2x_q;
    if (vid.en) begin
      if (vid.pxl2_cen) begin
        blank2x_d = ~rd_step | rd_word[8] | vb_l_q;
        rgb_d     = blank_rgb(blank2x_d, rd_word[7:0]);
        hs2x_d    = rd_step & ({1'b0, rd_x_q} < HSW_L);
        vs2x_d    = vs_l_q;
      end
    end else if (vid.pxl_cen) begin
      blank2x_d = vid.HB | vid.VB;
      rgb_d     = blank_rgb(blank2x_d, wr_word[7:0]);
      hs2x_d    = vid.HS;
      vs2x_d    = vid.VS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_l_q     <= 1'b0;
      bank_q     <= 1'b0;
      vb_l_q     <= 1'b0;
      vs_l_q     <= 1'b0;
      wr_ok_q    <= 1'b0;
      pass_q     <= 1'b0;
      done_q     <= 1'b1;
      wr_x_q     <= '0;
      rd_x_q     <= '0;
      line_len_q <= '0;
      rgb_q      <= '0;
      hs2x_q     <= 1'b0;
      vs2x_q     <= 1'b0;
      blank2x_q  <= 1'b0;
    end else begin
      hs_l_q     <= hs_l_d;
      bank_q     <= bank_d;
      vb_l_q     <= vb_l_d;
      vs_l_q     <= vs_l_d;
      wr_ok_q    <= wr_ok_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      wr_x_q     <= wr_x_d;
      rd_x_q     <= rd_x_d;
      line_len_q <= line_len_d;
      rgb_q      <= rgb_d;
      hs2x_q     <= hs2x_d;
      vs2x_q     <= vs2x_d;
      blank2x_q  <= blank2x_d;
    end
  end

  assign vid.red2x   = rgb_q[7:5];
  assign vid.green2x = rgb_q[4:2];
  assign vid.blue2x  = rgb_q[1:0];
  assign vid.HS2x    = hs2x_q;
  assign vid.VS2x    = vs2x_q;
  assign vid.blank2x = blank2x_q;
  assign vid.cen2x   = vid.en ? vid.pxl2_cen : vid.pxl_cen;
endmodule

// File: tb/tb_jtpopeye_scan2x.sv
// Bench for the Popeye line doubler: line-level reference model feeding an expected-output
// queue, with an independent monitor comparing every cen2x output tick.
module tb_jtpopeye_scan2x;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtpopeye_scan2x_if vif();
  jtpopeye_scan2x #(.AW(9), .HSW(32)) dut (.clk(clk), .rst_n(rst_n), .vid(vif));

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       blank;
  } out_t;

  out_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   en_cfg = 1'b1;
  bit   cen_seen = 1'b0;

  // Reference model: whole input lines are collected; at each line start the finished line
  // becomes the replay source, shown twice (at most) during the following line.
  logic [8:0] cur[$];
  logic [8:0] rep[$];
  bit         cur_clean, rep_ok, rep_vb, rep_vs, hs_prev;
  int         k;

  function automatic out_t actual();
    return {vif.red2x, vif.green2x, vif.blue2x, vif.HS2x, vif.VS2x, vif.blank2x};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got rgb=%h hs=%b vs=%b blank=%b, want rgb=%h hs=%b vs=%b blank=%b",
               name, $time, act.rgb, act.hs, act.vs, act.blank, exp.rgb, exp.hs, exp.vs, exp.blank);
    end
  endtask

  function automatic void model_reset();
    cur.delete();
    rep.delete();
    cur_clean = 1'b0;
    rep_ok    = 1'b0;
    rep_vb    = 1'b0;
    rep_vs    = 1'b0;
    hs_prev   = 1'b0;
    k         = 0;
  endfunction

  function automatic void model_pixel(input logic hb, input logic [7:0] rgb,
                                      input logic hs, input logic vb, input logic vs);
    if (!vif.en) cur_clean = 1'b0;
    if (hs && !hs_prev) begin
      rep       = cur;
      rep_ok    = cur_clean && vif.en && (cur.size() > 0);
      rep_vb    = vb;
      rep_vs    = vs;
      k         = 0;
      cur.delete();
      cur_clean = vif.en;
    end
    if (cur.size() < 511) cur.push_back({hb, rgb});
    hs_prev = hs;
  endfunction

  function automatic void model_tick2();
    out_t e;
    int   len;
    len = rep.size();
    e   = '0;
    if (rep_ok && k < 2 * len) begin
      int         idx;
      logic [8:0] w;
      idx     = k % len;
      w       = rep[idx];
      e.blank = w[8] | rep_vb;
      e.rgb   = e.blank ? 8'd0 : w[7:0];
      e.hs    = (idx < 32);
      e.vs    = rep_vs;
      k++;
    end else begin
      e.blank = 1'b1;
      e.vs    = rep_vs;
    end
    expq.push_back(e);
  endfunction

  always @(posedge clk) cen_seen <= rst_n && vif.cen2x;

  always @(negedge clk) begin
    if (cen_seen) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick at %0t: got output tick %h, want no tick", $time, actual());
      end else begin
        check("video_out", actual(), expq.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    vif.pxl_cen  = 1'b0;
    vif.pxl2_cen = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_clear", actual(), out_t'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_pixel(input logic hb, input logic [7:0] rgb,
                            input logic hs, input logic vb, input logic vs);
    for (int ph = 0; ph < 4; ph++) begin
      @(posedge clk); #1;
      vif.pxl_cen  = (ph == 0);
      vif.pxl2_cen = (ph == 1 || ph == 3);
      if (ph == 0) begin
        vif.en = en_cfg;
        {vif.red, vif.green, vif.blue} = rgb;
        vif.HB = hb;
        vif.VB = vb;
        vif.HS = hs;
        vif.VS = vs;
        if (!vif.en) begin
          out_t e;
          e.blank = hb | vb;
          e.rgb   = e.blank ? 8'd0 : rgb;
          e.hs    = hs;
          e.vs    = vs;
          expq.push_back(e);
        end
        model_pixel(hb, rgb, hs, vb, vs);
      end else if (ph != 2 && vif.en) begin
        model_tick2();
      end
    end
  endtask

  task automatic send_line(input int n, input bit ramp, input bit vb, input bit vs, input int rst_at);
    int hbt;
    hbt = ramp ? 0 : int'($urandom_range(0, 6));
    for (int x = 0; x < n; x++) begin
      logic [7:0] c;
      c = ramp ? 8'(x) : 8'($urandom);
      if (x == rst_at) do_reset();
      send_pixel(x >= n - hbt, c, x < 32, vb, vs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vif.pxl_cen = 1'b0; vif.pxl2_cen = 1'b0; vif.en = 1'b1;
    vif.red = '0; vif.green = '0; vif.blue = '0;
    vif.HB = 1'b0; vif.VB = 1'b0; vif.HS = 1'b0; vif.VS = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", actual(), out_t'(0));
    rst_n = 1'b1;

    // doubled ramp lines; the first window after reset is black
    repeat (3) send_line(384, 1'b1, 1'b0, 1'b0, -1);
    // random lines, one with VB/VS raised
    for (int i = 0; i < 8; i++)
      send_line(int'($urandom_range(40, 420)), 1'b0, i == 5, i == 5, -1);
    // overlong line saturates at 511 entries; then truncated / short replay windows
    send_line(600, 1'b1, 1'b0, 1'b0, -1);
    send_line(384, 1'b0, 1'b0, 1'b0, -1);
    send_line(300, 1'b0, 1'b0, 1'b0, -1);
    send_line(384, 1'b0, 1'b0, 1'b0, -1);
    send_line(60,  1'b0, 1'b0, 1'b0, -1);
    send_line(420, 1'b0, 1'b0, 1'b0, -1);
    // passthrough, then back to doubling at a line start
    en_cfg = 1'b0;
    for (int i = 0; i < 3; i++)
      send_line(int'($urandom_range(40, 200)), 1'b0, $urandom_range(0, 2) == 0, i == 1, -1);
    en_cfg = 1'b1;
    for (int i = 0; i < 3; i++)
      send_line(int'($urandom_range(100, 300)), 1'b0, 1'b0, 1'b0, -1);
    // reset during the first replay pass, then recovery two line starts later
    send_line(384, 1'b1, 1'b0, 1'b0, 50);
    repeat (3) send_line(int'($urandom_range(150, 384)), 1'b0, 1'b0, 1'b0, -1);

    @(posedge clk); #1;
    vif.pxl_cen  = 1'b0;
    vif.pxl2_cen = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected outputs never presented, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
